// File: rtl/iter_hasher.sv
// Iterative byte hasher: one rotate-xor round per message byte,
// then a length-mixing finalisation held until the consumer takes it.
module iter_hasher #(
  parameter int DATA_BYTES = 8,
  parameter int WIDTH = 32,
  parameter int ROT = 5,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(1),
  localparam int LEN_W = $clog2(DATA_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [LEN_W-1:0]        data_len,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        hash,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN,
    S_HOLD
  } state_t;

  state_t                  r_fsm;
  state_t                  w_nxt;
  logic [8*DATA_BYTES-1:0] r_data;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_cnt;
  logic [WIDTH-1:0]        r_st;
  logic [WIDTH-1:0]        r_hash;
  logic [LEN_W-1:0]        w_eff_len;
  logic [8*DATA_BYTES-1:0] w_sh;
  logic [7:0]              w_byte;
  logic                    w_last;
  logic                    w_accept;

  function automatic logic [WIDTH-1:0] rotl(
    input logic [WIDTH-1:0] x
  );
    return (x << ROT) | (x >> (WIDTH - ROT));
  endfunction

  // Oversized lengths saturate to the buffer size
  assign w_eff_len = (data_len > LEN_W'(DATA_BYTES))
                   ? LEN_W'(DATA_BYTES) : data_len;
  assign w_sh     = r_data >> {r_cnt, 3'b000};
  assign w_byte   = w_sh[7:0];
  assign w_last   = (r_cnt + LEN_W'(1)) == r_len;
  assign w_accept = in_valid & in_ready;
  assign hash     = r_hash;

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_nxt;
  end

  always_comb begin
    w_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:
        if (in_valid)
          w_nxt = (w_eff_len != '0) ? S_RUN : S_FIN;
      S_RUN:
        if (w_last) w_nxt = S_FIN;
      S_FIN:
        w_nxt = S_HOLD;
      S_HOLD:
        if (out_ready) w_nxt = S_IDLE;
      default:
        w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_fsm == S_IDLE);
    busy      = (r_fsm != S_IDLE);
    out_valid = (r_fsm == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_st   <= SEED;
      r_hash <= '0;
    end else begin
      case (r_fsm)
        S_IDLE:
          if (w_accept) begin
            r_data <= data;
            r_len  <= w_eff_len;
            r_cnt  <= '0;
            r_st   <= SEED;
          end
        S_RUN: begin
          r_st  <= rotl(r_st ^ WIDTH'(w_byte));
          r_cnt <= r_cnt + LEN_W'(1);
        end
        S_FIN:
          r_hash <= rotl(r_st) ^ WIDTH'(r_len);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_hasher.sv
// Directed vector bench for iter_hasher with default parameters.
module tb_iter_hasher;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] data;
  logic [3:0]  data_len;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] hash;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iter_hasher dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .data_len  (data_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hash      (hash),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0]  len;
    logic [63:0] data;
    logic [31:0] h;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one request, return hash and edges from acceptance to out_valid
  task automatic do_req(input logic [3:0] len,
                        input logic [63:0] d,
                        output logic [31:0] h,
                        output int lat);
    @(negedge clk);
    chk("in_ready_before_req", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    data     = d;
    data_len = len;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data     = {$urandom, $urandom};
    data_len = 4'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
    h = hash;
  endtask

  task automatic handshake(input logic [31:0] h);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    chk("hash_kept_after_hs", hash, h);
  endtask

  initial begin
    logic [31:0] h;
    int          lat;

    vecs[0] = '{4'd0,  64'h0123456789ABCDEF, 32'h00000020, 1};
    vecs[1] = '{4'd1,  64'hAAAAAAAAAAAAAA01, 32'h00000001, 2};
    vecs[2] = '{4'd2,  64'hFFFFFFFFFFFF0000, 32'h00008002, 3};
    vecs[3] = '{4'd3,  64'h0000000000030201, 32'h00010C03, 4};
    vecs[4] = '{4'd1,  64'h00000000000000FF, 32'h0003F801, 2};
    vecs[5] = '{4'd1,  64'h0000000000000080, 32'h00020401, 2};
    vecs[6] = '{4'd7,  64'hFF00000000000000, 32'h00000107, 8};
    vecs[7] = '{4'd15, 64'h0000000000000000, 32'h00002008, 9};
    vecs[8] = '{4'd9,  64'h0000000000000000, 32'h00002008, 9};

    rst       = 1'b1;
    in_valid  = 1'b1;
    data      = '0;
    data_len  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy_with_in_valid", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_hash", hash, 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;

    foreach (vecs[i]) begin
      do_req(vecs[i].len, vecs[i].data, h, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_hash", i), h, vecs[i].h);
      handshake(vecs[i].h);
    end

    // Back-pressure: output must hold while inputs churn
    do_req(4'd3, 64'h0000000000030201, h, lat);
    chk("hold_lat", 32'(lat), 32'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      data     = {$urandom, $urandom};
      data_len = 4'($urandom);
      @(posedge clk);
      #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_hash", hash, 32'h00010C03);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    handshake(32'h00010C03);

    // Reset during the third RUN cycle of an 8-byte request
    @(negedge clk);
    in_valid = 1'b1;
    data     = 64'h1122334455667788;
    data_len = 4'd8;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_run_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_run_in_ready", 32'(in_ready), 32'd1);
    chk("rst_run_out_valid", 32'(out_valid), 32'd0);
    chk("rst_run_hash", hash, 32'd0);
    chk("rst_run_busy", 32'(busy), 32'd0);
    do_req(4'd0, 64'h0, h, lat);
    chk("post_rst_lat", 32'(lat), 32'd1);
    chk("post_rst_hash", h, 32'h00000020);

    // Reset while holding an output
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_hold_out_valid", 32'(out_valid), 32'd0);
    chk("rst_hold_hash", hash, 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_hold_no_output", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/iter_hasher.md
ITER_HASHER -- requirements
Module: iter_hasher

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 8: maximum message length in bytes, at least 1.
REQ-002 SHALL have parameter WIDTH, default 32: hash/state width in bits, at least 8.
REQ-003 SHALL have parameter ROT, default 5: left-rotate distance per round, 0..WIDTH-1.
REQ-004 SHALL have parameter SEED, default 1 (WIDTH bits): initial state value.
REQ-005 SHALL derive LEN_W = clog2(DATA_BYTES+1), which is 4 at default.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1 bit: a request is present.
REQ-009 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-010 SHALL have port data, input, 8*DATA_BYTES bits: message, byte i = data[8i+7:8i].
REQ-011 SHALL have port data_len, input, LEN_W bits: number of valid bytes.
REQ-012 SHALL have port out_valid, output, 1 bit: hash is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the hash.
REQ-014 SHALL have port hash, output, WIDTH bits: result.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN, FIN and HOLD.
REQ-017 SHALL drive in_ready = 1 only in IDLE; acceptance occurs when in_valid && in_ready at a rising edge.
REQ-018 On acceptance, SHALL register data, set eff_len = min(data_len, DATA_BYTES), set state = SEED and count = 0, then go to RUN if eff_len > 0, else go to FIN.
REQ-019 In RUN, SHALL process one byte per cycle in order byte 0 first: state <= rotl(state ^ zero_ext(byte[count]), ROT), count <= count + 1.
REQ-020 In RUN, SHALL go to FIN on the edge that consumes byte eff_len-1.
REQ-021 In FIN, SHALL register hash <= rotl(state, ROT) ^ zero_ext(eff_len), set out_valid = 1, and go to HOLD.
REQ-022 In HOLD, SHALL keep out_valid = 1 and hold hash stable until out_ready is sampled high, then go to IDLE with out_valid = 0.
REQ-023 SHALL make out_valid rise exactly eff_len+1 cycles after the acceptance edge.
REQ-024 SHALL not accept a new request in the cycle of the output handshake; in_ready first rises the cycle after the return to IDLE.
REQ-025 SHALL ignore in_valid and input changes outside IDLE, with no effect on the in-flight computation.
REQ-026 SHALL use only the registered copy of data and data_len after acceptance.
REQ-027 SHALL treat data_len values greater than DATA_BYTES as DATA_BYTES, both for the round count and for the final XOR.
REQ-028 SHALL compute all arithmetic modulo 2^WIDTH, with rotl circular over WIDTH bits.
REQ-029 SHALL keep hash holding its last value after the handshake until the next FIN.

Reset
REQ-030 While rst is high at an edge, SHALL go to IDLE with out_valid = 0, hash = 0, count = 0, state = SEED and busy = 0, irrespective of the current state.
REQ-031 Reset mid-RUN or mid-HOLD SHALL abort the operation and produce no output handshake for it.
REQ-032 SHALL not accept in_valid at an edge where rst is high.

Verification
REQ-033 With defaults, data_len=0 -> out_valid 1 cycle after acceptance and hash = 32'h00000020.
REQ-034 With defaults, data_len=1 and byte0=8'h01 -> out_valid 2 cycles after acceptance and hash = 32'h00000001.
REQ-035 With defaults, data_len=2 and bytes 8'h00,8'h00 -> out_valid 3 cycles after acceptance and hash = 32'h00008002.
REQ-036 With data_len=15 on the default configuration -> the block processes 8 bytes, out_valid rises 9 cycles after acceptance, and the final XOR uses 8.
REQ-037 Holding out_ready=0 for 5 cycles -> out_valid and hash stay stable and in_ready stays 0; when out_ready=1, IDLE follows on the next cycle.
REQ-038 Asserting rst in the 3rd RUN cycle of an 8-byte request -> the next cycle shows in_ready=1, out_valid=0 and hash=0; a subsequent data_len=0 request then yields 32'h00000020.
